// File: rtl/vga_fill_arbiter.sv
// -----------------------------------------------------------------------------
// vga_fill_arbiter
//
// Shares the framebuffer adapter's single plot port between CPU pixel writes
// and a hardware rectangle-fill engine. CPU writes have fixed top priority;
// the fill engine only issues a pixel on cycles where the CPU does not plot.
// All adapter-facing outputs are registered (one cycle from input to adapter).
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous active-high reset
//   cpu_wenable  CPU pixel write strobe
//   cpu_waddr    CPU pixel address, [6:0]=x, [13:7]=y
//   cpu_wdata    CPU pixel colour
//   fill_start   single-cycle fill request (honoured only when idle)
//   fill_x0/y0   rectangle top-left corner, inclusive
//   fill_x1/y1   rectangle bottom-right corner, inclusive
//   fill_colour  fill colour
//   fill_busy    high while a fill is in progress
//   fill_done    one-cycle pulse when a fill completes
//   plot         pixel write strobe to the adapter
//   x, y, colour pixel coordinates and colour to the adapter
// -----------------------------------------------------------------------------
module vga_fill_arbiter #(
    parameter int X_BITS      = 8,
    parameter int Y_BITS      = 7,
    parameter int COLOUR_BITS = 15,
    parameter int MAX_X       = 159,
    parameter int MAX_Y       = 119
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cpu_wenable,
    input  logic [13:0]            cpu_waddr,
    input  logic [COLOUR_BITS-1:0] cpu_wdata,
    input  logic                   fill_start,
    input  logic [X_BITS-1:0]      fill_x0,
    input  logic [Y_BITS-1:0]      fill_y0,
    input  logic [X_BITS-1:0]      fill_x1,
    input  logic [Y_BITS-1:0]      fill_y1,
    input  logic [COLOUR_BITS-1:0] fill_colour,
    output logic                   fill_busy,
    output logic                   fill_done,
    output logic                   plot,
    output logic [X_BITS-1:0]      x,
    output logic [Y_BITS-1:0]      y,
    output logic [COLOUR_BITS-1:0] colour
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_r;
    logic [X_BITS-1:0]      x0_r;
    logic [X_BITS-1:0]      x1_r;
    logic [X_BITS-1:0]      cx_r;
    logic [Y_BITS-1:0]      y0_r;
    logic [Y_BITS-1:0]      y1_r;
    logic [Y_BITS-1:0]      cy_r;
    logic [COLOUR_BITS-1:0] fill_colour_r;

    logic [X_BITS-1:0]      clamp_x0_s;
    logic [X_BITS-1:0]      clamp_x1_s;
    logic [Y_BITS-1:0]      clamp_y0_s;
    logic [Y_BITS-1:0]      clamp_y1_s;
    logic                   empty_s;
    logic                   row_end_s;
    logic                   last_s;

    function automatic logic [X_BITS-1:0] clamp_x(input logic [X_BITS-1:0] v);
        if (v > X_BITS'(MAX_X)) begin
            return X_BITS'(MAX_X);
        end else begin
            return v;
        end
    endfunction

    function automatic logic [Y_BITS-1:0] clamp_y(input logic [Y_BITS-1:0] v);
        if (v > Y_BITS'(MAX_Y)) begin
            return Y_BITS'(MAX_Y);
        end else begin
            return v;
        end
    endfunction

    // Clamp the request at latch time so the cursor never leaves the screen.
    always_comb begin
        clamp_x0_s = clamp_x(fill_x0);
        clamp_x1_s = clamp_x(fill_x1);
        clamp_y0_s = clamp_y(fill_y0);
        clamp_y1_s = clamp_y(fill_y1);
        empty_s    = (clamp_x0_s > clamp_x1_s) || (clamp_y0_s > clamp_y1_s);
    end

    // Cursor position flags: end of the current row, and the final pixel.
    always_comb begin
        row_end_s = (cx_r == x1_r);
        last_s    = row_end_s && (cy_r == y1_r);
    end

    // Fill FSM, cursor and registered adapter outputs. The CPU pixel wins
    // every cycle it is present; the fill cursor simply holds on those cycles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r       <= IDLE;
            x0_r          <= '0;
            x1_r          <= '0;
            cx_r          <= '0;
            y0_r          <= '0;
            y1_r          <= '0;
            cy_r          <= '0;
            fill_colour_r <= '0;
            fill_busy     <= 1'b0;
            fill_done     <= 1'b0;
            plot          <= 1'b0;
            x             <= '0;
            y             <= '0;
            colour        <= '0;
        end else begin
            // Strobes default low; x/y/colour hold unless a pixel is issued.
            plot      <= 1'b0;
            fill_done <= 1'b0;

            if (cpu_wenable) begin
                plot   <= 1'b1;
                x      <= X_BITS'(cpu_waddr[6:0]);   // CPU reaches x 0..127 only
                y      <= Y_BITS'(cpu_waddr[13:7]);
                colour <= cpu_wdata;
            end else begin
                plot <= 1'b0;
            end

            case (state_r)
                IDLE: begin
                    fill_busy <= 1'b0;
                    if (fill_start) begin
                        x0_r          <= clamp_x0_s;
                        x1_r          <= clamp_x1_s;
                        y0_r          <= clamp_y0_s;
                        y1_r          <= clamp_y1_s;
                        cx_r          <= clamp_x0_s;
                        cy_r          <= clamp_y0_s;
                        fill_colour_r <= fill_colour;
                        if (empty_s) begin
                            state_r <= DONE;
                        end else begin
                            state_r   <= FILL;
                            fill_busy <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                FILL: begin
                    // Requests arriving here are dropped, not queued.
                    if (!cpu_wenable) begin
                        plot   <= 1'b1;
                        x      <= cx_r;
                        y      <= cy_r;
                        colour <= fill_colour_r;
                        if (last_s) begin
                            state_r   <= DONE;
                            fill_busy <= 1'b0;
                        end else if (row_end_s) begin
                            cx_r <= x0_r;
                            cy_r <= cy_r + Y_BITS'(1);
                        end else begin
                            cx_r <= cx_r + X_BITS'(1);
                        end
                    end else begin
                        state_r <= FILL;
                    end
                end
                DONE: begin
                    fill_done <= 1'b1;
                    fill_busy <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    fill_busy <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_fill_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vga_fill_arbiter
//
// Directed, table-driven bench for vga_fill_arbiter: a vector table covers CPU
// writes, a plain fill, a fill interleaved with CPU writes, a simultaneous
// CPU write + fill request and an empty (clamped) rectangle. Hand-written
// sequences cover a large clamped fill with an ignored restart, a clamped
// single-pixel fill and an asynchronous reset in the middle of a fill.
// -----------------------------------------------------------------------------
module tb_vga_fill_arbiter;

    logic        clock;
    logic        reset;
    logic        cpu_wenable;
    logic [13:0] cpu_waddr;
    logic [14:0] cpu_wdata;
    logic        fill_start;
    logic [7:0]  fill_x0;
    logic [6:0]  fill_y0;
    logic [7:0]  fill_x1;
    logic [6:0]  fill_y1;
    logic [14:0] fill_colour;
    logic        fill_busy;
    logic        fill_done;
    logic        plot;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [14:0] colour;

    int checks = 0;
    int errors = 0;

    vga_fill_arbiter dut (
        .clock       (clock),
        .reset       (reset),
        .cpu_wenable (cpu_wenable),
        .cpu_waddr   (cpu_waddr),
        .cpu_wdata   (cpu_wdata),
        .fill_start  (fill_start),
        .fill_x0     (fill_x0),
        .fill_y0     (fill_y0),
        .fill_x1     (fill_x1),
        .fill_y1     (fill_y1),
        .fill_colour (fill_colour),
        .fill_busy   (fill_busy),
        .fill_done   (fill_done),
        .plot        (plot),
        .x           (x),
        .y           (y),
        .colour      (colour)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        cwe;
        logic [13:0] caddr;
        logic [14:0] cdata;
        logic        fs;
        logic [7:0]  fx0;
        logic [6:0]  fy0;
        logic [7:0]  fx1;
        logic [6:0]  fy1;
        logic [14:0] fcol;
        logic        e_plot;
        logic [7:0]  e_x;
        logic [6:0]  e_y;
        logic [14:0] e_col;
        logic        e_busy;
        logic        e_done;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic cwe, input logic [13:0] caddr, input logic [14:0] cdata,
                       input logic fs, input logic [7:0] fx0, input logic [6:0] fy0,
                       input logic [7:0] fx1, input logic [6:0] fy1, input logic [14:0] fcol,
                       input logic e_plot, input logic [7:0] e_x, input logic [6:0] e_y,
                       input logic [14:0] e_col, input logic e_busy, input logic e_done);
        vec_t v;
        v.cwe = cwe; v.caddr = caddr; v.cdata = cdata; v.fs = fs;
        v.fx0 = fx0; v.fy0 = fy0; v.fx1 = fx1; v.fy1 = fy1; v.fcol = fcol;
        v.e_plot = e_plot; v.e_x = e_x; v.e_y = e_y; v.e_col = e_col;
        v.e_busy = e_busy; v.e_done = e_done;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic cwe, input logic [13:0] caddr, input logic [14:0] cdata,
                         input logic fs, input logic [7:0] fx0, input logic [6:0] fy0,
                         input logic [7:0] fx1, input logic [6:0] fy1, input logic [14:0] fcol);
        cpu_wenable = cwe; cpu_waddr = caddr; cpu_wdata = cdata;
        fill_start  = fs;  fill_x0 = fx0; fill_y0 = fy0; fill_x1 = fx1; fill_y1 = fy1;
        fill_colour = fcol;
    endtask

    task automatic idle_in();
        drive(1'b0, 14'h0000, 15'h0000, 1'b0, 8'd0, 7'd0, 8'd0, 7'd0, 15'h0000);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_pixel(input string nm, input logic [7:0] ex, input logic [6:0] ey,
                               input logic [14:0] ec);
        check({nm, ".plot"}, 32'(plot), 32'd1);
        check({nm, ".x"}, 32'(x), 32'(ex));
        check({nm, ".y"}, 32'(y), 32'(ey));
        check({nm, ".colour"}, 32'(colour), 32'(ec));
    endtask

    initial begin
        // ---------------- vector table ----------------
        // CPU write: waddr 0x0285 -> x=5, y=5
        add(1'b1, 14'h0285, 15'h7C00, 1'b0, 8'd0, 7'd0, 8'd0, 7'd0, 15'h0000, 1'b1, 8'd5, 7'd5, 15'h7C00, 1'b0, 1'b0);
        add(1'b0, 14'h0000, 15'h0000, 1'b0, 8'd0, 7'd0, 8'd0, 7'd0, 15'h0000, 1'b0, 8'd0, 7'd0, 15'h0000, 1'b0, 1'b0);
        // Fill (2,3)-(4,4) colour 001F, no CPU traffic
        add(1'b0, 14'h0000, 15'h0000, 1'b1, 8'd2, 7'd3, 8'd4, 7'd4, 15'h001F, 1'b0, 8'd0, 7'd0, 15'h0000, 1'b1, 1'b0);
        add(1'b0, 14'h0000, 15'h0000, 1'b0, 8'd0, 7'd0, 8'd0, 7'd0, 15'h0000, 1'b1, 8'd2, 7'd3, 15'h001F, 1'b1, 1'b0);
        add(1'b0, 14'h0000, 15'h0000, 1'b0, 8'd0, 7'd0, 8'd0, 7'd0, 15'h0000, 1'b1, 8'd3, 7'd3, 15'h001F, 1'b1, 1'b0);
        add(1'b0, 14'h0000, 15'h0000, 1'b0, 8'd0, 7'd0, 8'd0, 7'd0, 15'h0000, 1'b1, 8'd4, 7'd3, 15'h001F, 1'b1, 1'b0);
        add(1'b0, 14'h0000, 15'h0000, 1'b0, 8'd0, 7'd0, 8'd0, 7'd0, 15'h0000, 1'b1, 8'd2, 7'd4, 15'h001F, 1'b1, 1'b0);
        add(1'b0, 14'h0000, 15'h0000, 1'b0, 8'd0, 7'd0, 8'd0, 7'd0, 15'h0000, 1'b1, 8'd3, 7'd4, 15'h001F, 1'b1, 1'b0);
        add(1'b0, 14'h0000, 15'h0000, 1'b0, 8'd0, 7'd0, 8'd0, 7'd0, 15'h0000, 1'b1, 8'd4, 7'd4, 15'h001F, 1'b0, 1'b0);
        add(1'b0, 14'h0000, 15'h0000, 1'b0, 8'd0, 7'd0, 8'd0, 7'd0, 15'h0000, 1'b0, 8'd0, 7'd0, 15'h0000, 1'b0, 1'b1);
        add(1'b0, 14'h0000, 15'h0000, 1'b0, 8'd0, 7'd0, 8'd0, 7'd0, 15'h0000, 1'b0, 8'd0, 7'd0, 15'h0000, 1'b0, 1'b0);
        // Same fill, CPU writes on the 2nd and 4th FILL cycles
        add(1'b0, 14'h0000, 15'h0000, 1'b1, 8'd2, 7'd3, 8'd4, 7'd4, 15'h001F, 1'b0, 8'd0, 7'd0, 15'h0000, 1'b1, 1'b0);
        add(1'b0, 14'h0000, 15'h0000, 1'b0, 8'd0, 7'd0, 8'd0, 7'd0, 15'h0000, 1'b1, 8'd2, 7'd3, 15'h001F, 1'b1, 1'b0);
        add(1'b1, 14'h0514, 15'h03E0, 1'b0, 8'd0, 7'd0, 8'd0, 7'd0, 15'h0000, 1'b1, 8'd20, 7'd10, 15'h03E0, 1'b1, 1'b0);
        add(1'b0, 14'h0000, 15'h0000, 1'b0, 8'd0, 7'd0, 8'd0, 7'd0, 15'h0000, 1'b1, 8'd3, 7'd3, 15'h001F, 1'b1, 1'b0);
        add(1'b1, 14'h3FFF, 15'h7FFF, 1'b0, 8'd0, 7'd0, 8'd0, 7'd0, 15'h0000, 1'b1, 8'd127, 7'd127, 15'h7FFF, 1'b1, 1'b0);
        add(1'b0, 14'h0000, 15'h0000, 1'b0, 8'd0, 7'd0, 8'd0, 7'd0, 15'h0000, 1'b1, 8'd4, 7'd3, 15'h001F, 1'b1, 1'b0);
        add(1'b0, 14'h0000, 15'h0000, 1'b0, 8'd0, 7'd0, 8'd0, 7'd0, 15'h0000, 1'b1, 8'd2, 7'd4, 15'h001F, 1'b1, 1'b0);
        add(1'b0, 14'h0000, 15'h0000, 1'b0, 8'd0, 7'd0, 8'd0, 7'd0, 15'h0000, 1'b1, 8'd3, 7'd4, 15'h001F, 1'b1, 1'b0);
        add(1'b0, 14'h0000, 15'h0000, 1'b0, 8'd0, 7'd0, 8'd0, 7'd0, 15'h0000, 1'b1, 8'd4, 7'd4, 15'h001F, 1'b0, 1'b0);
        add(1'b0, 14'h0000, 15'h0000, 1'b0, 8'd0, 7'd0, 8'd0, 7'd0, 15'h0000, 1'b0, 8'd0, 7'd0, 15'h0000, 1'b0, 1'b1);
        add(1'b0, 14'h0000, 15'h0000, 1'b0, 8'd0, 7'd0, 8'd0, 7'd0, 15'h0000, 1'b0, 8'd0, 7'd0, 15'h0000, 1'b0, 1'b0);
        // CPU write and fill_start together in IDLE: CPU pixel out, fill accepted
        add(1'b1, 14'h0101, 15'h1234, 1'b1, 8'd0, 7'd0, 8'd1, 7'd0, 15'h5555, 1'b1, 8'd1, 7'd2, 15'h1234, 1'b1, 1'b0);
        add(1'b0, 14'h0000, 15'h0000, 1'b0, 8'd0, 7'd0, 8'd0, 7'd0, 15'h0000, 1'b1, 8'd0, 7'd0, 15'h5555, 1'b1, 1'b0);
        add(1'b0, 14'h0000, 15'h0000, 1'b0, 8'd0, 7'd0, 8'd0, 7'd0, 15'h0000, 1'b1, 8'd1, 7'd0, 15'h5555, 1'b0, 1'b0);
        add(1'b0, 14'h0000, 15'h0000, 1'b0, 8'd0, 7'd0, 8'd0, 7'd0, 15'h0000, 1'b0, 8'd0, 7'd0, 15'h0000, 1'b0, 1'b1);
        add(1'b0, 14'h0000, 15'h0000, 1'b0, 8'd0, 7'd0, 8'd0, 7'd0, 15'h0000, 1'b0, 8'd0, 7'd0, 15'h0000, 1'b0, 1'b0);
        // Empty after clamping: x0=200->159 > x1=150; zero plots, done pulses
        add(1'b0, 14'h0000, 15'h0000, 1'b1, 8'd200, 7'd127, 8'd150, 7'd127, 15'h0AAA, 1'b0, 8'd0, 7'd0, 15'h0000, 1'b0, 1'b0);
        add(1'b0, 14'h0000, 15'h0000, 1'b0, 8'd0, 7'd0, 8'd0, 7'd0, 15'h0000, 1'b0, 8'd0, 7'd0, 15'h0000, 1'b0, 1'b1);
        add(1'b0, 14'h0000, 15'h0000, 1'b0, 8'd0, 7'd0, 8'd0, 7'd0, 15'h0000, 1'b0, 8'd0, 7'd0, 15'h0000, 1'b0, 1'b0);

        // ---------------- reset state ----------------
        reset = 1'b1;
        idle_in();
        #12;
        check("rst.plot", 32'(plot), 32'd0);
        check("rst.x", 32'(x), 32'd0);
        check("rst.y", 32'(y), 32'd0);
        check("rst.colour", 32'(colour), 32'd0);
        check("rst.busy", 32'(fill_busy), 32'd0);
        check("rst.done", 32'(fill_done), 32'd0);
        reset = 1'b0;

        // ---------------- table ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].cwe, vecs[i].caddr, vecs[i].cdata, vecs[i].fs,
                  vecs[i].fx0, vecs[i].fy0, vecs[i].fx1, vecs[i].fy1, vecs[i].fcol);
            step();
            check($sformatf("v%0d.plot", i), 32'(plot), 32'(vecs[i].e_plot));
            check($sformatf("v%0d.busy", i), 32'(fill_busy), 32'(vecs[i].e_busy));
            check($sformatf("v%0d.done", i), 32'(fill_done), 32'(vecs[i].e_done));
            if (vecs[i].e_plot) begin
                check($sformatf("v%0d.x", i), 32'(x), 32'(vecs[i].e_x));
                check($sformatf("v%0d.y", i), 32'(y), 32'(vecs[i].e_y));
                check($sformatf("v%0d.colour", i), 32'(colour), 32'(vecs[i].e_col));
            end
        end

        // ------- clamped 10x2 fill (150,118)-(255,127), restart ignored -------
        drive(1'b0, 14'h0000, 15'h0000, 1'b1, 8'd150, 7'd118, 8'd255, 7'd127, 15'h2AAA);
        step();
        check("big.busy_rise", 32'(fill_busy), 32'd1);
        for (int k = 0; k < 20; k++) begin
            if (k == 5) begin
                drive(1'b0, 14'h0000, 15'h0000, 1'b1, 8'd0, 7'd0, 8'd0, 7'd0, 15'h7FFF);
            end else begin
                idle_in();
            end
            step();
            check_pixel($sformatf("big%0d", k), 8'(150 + (k % 10)), 7'(118 + (k / 10)), 15'h2AAA);
        end
        idle_in();
        step();
        check("big.done", 32'(fill_done), 32'd1);
        check("big.plot_after", 32'(plot), 32'd0);
        step();
        check("big.no_restart_plot", 32'(plot), 32'd0);
        check("big.no_restart_busy", 32'(fill_busy), 32'd0);
        check("big.done_clear", 32'(fill_done), 32'd0);

        // ------- single pixel clamped to the bottom-right corner -------
        drive(1'b0, 14'h0000, 15'h0000, 1'b1, 8'd255, 7'd127, 8'd255, 7'd127, 15'h0001);
        step();
        idle_in();
        step();
        check_pixel("corner", 8'd159, 7'd119, 15'h0001);
        step();
        check("corner.done", 32'(fill_done), 32'd1);

        // ------- asynchronous reset after 3 plots of a fill -------
        step();
        drive(1'b0, 14'h0000, 15'h0000, 1'b1, 8'd0, 7'd0, 8'd9, 7'd0, 15'h0F0F);
        step();
        idle_in();
        for (int k = 0; k < 3; k++) begin
            step();
            check_pixel($sformatf("pre_rst%0d", k), 8'(k), 7'd0, 15'h0F0F);
        end
        #2;
        reset = 1'b1;
        #1;
        check("arst.plot", 32'(plot), 32'd0);
        check("arst.x", 32'(x), 32'd0);
        check("arst.colour", 32'(colour), 32'd0);
        check("arst.busy", 32'(fill_busy), 32'd0);
        step();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("post_rst%0d.plot", k), 32'(plot), 32'd0);
            check($sformatf("post_rst%0d.done", k), 32'(fill_done), 32'd0);
        end
        drive(1'b0, 14'h0000, 15'h0000, 1'b1, 8'd5, 7'd5, 8'd5, 7'd5, 15'h0123);
        step();
        check("after_rst.busy", 32'(fill_busy), 32'd1);
        idle_in();
        step();
        check_pixel("after_rst", 8'd5, 7'd5, 15'h0123);
        step();
        check("after_rst.done", 32'(fill_done), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
